// File: rtl/capture_readout_if.sv
// Readout bus: RAM read port toward the sample memory plus the byte stream toward the TX framer.
// The master side is the readout engine; the slave side is the RAM and the stream consumer.
interface capture_readout_if #(
  parameter int SAMPLE_DEPTH = 8
);
  logic [SAMPLE_DEPTH-1:0] mem_addr;
  logic                    mem_re;
  logic [7:0]              mem_rdata;
  logic [7:0]              tx_data;
  logic                    tx_valid;
  logic                    tx_ready;

  modport master (
    output mem_addr, mem_re, tx_data, tx_valid,
    input  mem_rdata, tx_ready
  );

  modport slave (
    input  mem_addr, mem_re, tx_data, tx_valid,
    output mem_rdata, tx_ready
  );
endinterface

// File: rtl/capture_readout.sv
// Unrolls the circular sample RAM into a time-ordered byte stream: sync byte, then 2^SAMPLE_DEPTH
// samples starting PRE_TRIG before the trigger. Define READOUT_CHECKSUM_EN to append an XOR checksum byte.
module capture_readout #(
  parameter int          SAMPLE_DEPTH = 8,
  parameter int          PRE_TRIG     = 128,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                    clk_50mhz,
  input  logic                    reset,
  input  logic                    activate,
  output logic                    done,
  input  logic [SAMPLE_DEPTH-1:0] trig_offset,
  output logic                    busy,
  capture_readout_if.master       bus
);

  localparam logic [SAMPLE_DEPTH-1:0] PRE_OFS  = SAMPLE_DEPTH'(PRE_TRIG);
  localparam logic [SAMPLE_DEPTH:0]   LAST_CNT = {1'b0, {SAMPLE_DEPTH{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_FETCH,
    S_LOAD,
    S_SEND,
`ifdef READOUT_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_e;

  state_e                  state_q;
  logic [SAMPLE_DEPTH-1:0] start_q;
  logic [SAMPLE_DEPTH:0]   cnt_q;
  logic [SAMPLE_DEPTH:0]   cnt_d;
  logic [SAMPLE_DEPTH-1:0] addr_d;
  logic [SAMPLE_DEPTH-1:0] mem_addr_q;
  logic                    mem_re_q;
  logic [7:0]              tx_data_q;
  logic                    tx_valid_q;
  logic                    done_q;
  logic                    busy_q;
  logic                    hs;
`ifdef READOUT_CHECKSUM_EN
  logic [7:0]              csum_q;
`endif

  assign hs     = tx_valid_q & bus.tx_ready;
  assign cnt_d  = cnt_q + 1'b1;
  // Address arithmetic is deliberately SAMPLE_DEPTH bits so it wraps around the circular RAM.
  assign addr_d = start_q + cnt_d[SAMPLE_DEPTH-1:0];

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      state_q    <= S_IDLE;
      start_q    <= '0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_re_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (activate) begin
            start_q    <= trig_offset - PRE_OFS;
            cnt_q      <= '0;
            tx_data_q  <= SYNC_BYTE;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
`ifdef READOUT_CHECKSUM_EN
            csum_q     <= '0;
`endif
            state_q    <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (hs) begin
            tx_valid_q <= 1'b0;
            mem_addr_q <= start_q;
            mem_re_q   <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          mem_re_q <= 1'b0;
          state_q  <= S_LOAD;
        end
        S_LOAD: begin
          tx_data_q  <= bus.mem_rdata;
          tx_valid_q <= 1'b1;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          if (hs) begin
`ifdef READOUT_CHECKSUM_EN
            csum_q <= csum_q ^ tx_data_q;
`endif
            if (cnt_q == LAST_CNT) begin
`ifdef READOUT_CHECKSUM_EN
              // The last sample is folded in here; csum_q only lands on the same edge.
              tx_data_q <= csum_q ^ tx_data_q;
              state_q   <= S_CHECK;
`else
              tx_valid_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= S_DONE;
`endif
            end else begin
              cnt_q      <= cnt_d;
              tx_valid_q <= 1'b0;
              mem_addr_q <= addr_d;
              mem_re_q   <= 1'b1;
              state_q    <= S_FETCH;
            end
          end
        end
`ifdef READOUT_CHECKSUM_EN
        S_CHECK: begin
          if (hs) begin
            tx_valid_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (!activate) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_re   = mem_re_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign done         = done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_capture_readout.sv
// Scoreboard bench for capture_readout: a reference model queues expected bytes and RAM addresses,
// a negedge monitor pops and compares on every handshake / read. Honours READOUT_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_capture_readout;
  localparam int         SD   = 8;
  localparam int         PRE  = 128;
  localparam int         N    = 1 << SD;
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef READOUT_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic          clk_50mhz = 1'b0;
  logic          reset;
  logic          activate;
  logic          done;
  logic          busy;
  logic [SD-1:0] trig_offset;

  capture_readout_if #(.SAMPLE_DEPTH(SD)) bus_if ();

  capture_readout #(
    .SAMPLE_DEPTH(SD),
    .PRE_TRIG    (PRE),
    .SYNC_BYTE   (SYNC)
  ) dut (
    .clk_50mhz  (clk_50mhz),
    .reset      (reset),
    .activate   (activate),
    .done       (done),
    .trig_offset(trig_offset),
    .busy       (busy),
    .bus        (bus_if.master)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  // Synchronous-read sample RAM
  logic [7:0] mem [N];
  always @(posedge clk_50mhz) begin
    if (bus_if.mem_re === 1'b1) bus_if.mem_rdata <= mem[bus_if.mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0]    exp_q [$];
  logic [SD-1:0] addr_q [$];
  int            accepted = 0;
  logic [7:0]    last_byte = 8'h00;
  bit            ready_rand = 1'b0;

  // Consumer ready: always 1, or a ~50% coin flip per cycle
  initial begin
    bus_if.tx_ready = 1'b1;
    forever begin
      @(posedge clk_50mhz);
      #1;
      bus_if.tx_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares every accepted byte and every RAM read against the queued expectations
  bit         hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;
  always @(negedge clk_50mhz) begin
    if (hold_v) begin
      check("valid_held", 32'(bus_if.tx_valid), 32'd1);
      check("data_stable", 32'(bus_if.tx_data), 32'(hold_d));
    end
    hold_v = (bus_if.tx_valid === 1'b1) && (bus_if.tx_ready === 1'b0) && (reset === 1'b0);
    hold_d = bus_if.tx_data;
    if ((bus_if.tx_valid === 1'b1) && (bus_if.tx_ready === 1'b1) && (reset === 1'b0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %0h expected none", bus_if.tx_data);
      end else begin
        check("byte", 32'(bus_if.tx_data), 32'(exp_q.pop_front()));
      end
      accepted++;
      last_byte = bus_if.tx_data;
    end
    if ((bus_if.mem_re === 1'b1) && (reset === 1'b0)) begin
      if (addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got %0h expected none", bus_if.mem_addr);
      end else begin
        check("mem_addr", 32'(bus_if.mem_addr), 32'(addr_q.pop_front()));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_50mhz);
    #1;
  endtask

  task automatic load_mem(input bit random);
    for (int i = 0; i < N; i++) mem[i] = random ? 8'($urandom) : 8'(i);
  endtask

  // Reference model: the frame is the RAM read in time order from trigger-PRE, wrapping around
  task automatic expect_frame(input logic [SD-1:0] trig);
    logic [SD-1:0] a;
    logic [7:0]    x;
    x = 8'h00;
    exp_q.push_back(SYNC);
    for (int k = 0; k < N; k++) begin
      a = SD'((int'(trig) - PRE + k + N) % N);
      addr_q.push_back(a);
      exp_q.push_back(mem[a]);
      x ^= mem[a];
    end
    if (CSUM != 0) exp_q.push_back(x);
  endtask

  task automatic run_frame(input logic [SD-1:0] trig, input bit drop_early, input bit check_latency);
    int cyc;
    int busy_low;
    int acc0;
    cyc      = 0;
    busy_low = 0;
    acc0     = accepted;
    expect_frame(trig);
    trig_offset = trig;
    activate    = 1'b1;
    while (done !== 1'b1 && cyc < 5000) begin
      @(posedge clk_50mhz);
      #1;
      cyc++;
      if (busy !== 1'b1) busy_low++;
      if (drop_early && accepted > acc0) activate = 1'b0;
    end
    check("done_seen", 32'(done), 32'd1);
    if (check_latency) check("done_latency", 32'(cyc), 32'(1 + 3 * N + CSUM + 1));
    check("busy_during_frame", 32'(busy_low), 32'd0);
    check("frame_len", 32'(accepted - acc0), 32'(1 + N + CSUM));
    check("exp_drained", 32'(exp_q.size()), 32'd0);
    check("addr_drained", 32'(addr_q.size()), 32'd0);
    check("valid_in_done", 32'(bus_if.tx_valid), 32'd0);
    if (drop_early) begin
      tick(1);
      check("done_one_cycle", 32'(done), 32'd0);
    end else begin
      tick(2);
      check("done_held", 32'(done), 32'd1);
      activate = 1'b0;
      tick(1);
      check("done_cleared", 32'(done), 32'd0);
    end
    check("busy_idle", 32'(busy), 32'd0);
    exp_q.delete();
    addr_q.delete();
    tick(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_tx_valid"}, 32'(bus_if.tx_valid), 32'd0);
    check({tag, "_tx_data"}, 32'(bus_if.tx_data), 32'd0);
    check({tag, "_mem_re"}, 32'(bus_if.mem_re), 32'd0);
    check({tag, "_mem_addr"}, 32'(bus_if.mem_addr), 32'd0);
  endtask

  initial begin
    int cyc;
    int acc0;
    bus_if.mem_rdata = 8'h00;
    reset       = 1'b1;
    activate    = 1'b0;
    trig_offset = '0;
    tick(3);
    check_reset_outputs("rst");
    reset = 1'b0;
    tick(2);

    // Identity RAM: nominal trigger, then one that wraps the start address
    load_mem(1'b0);
    run_frame(8'h10, 1'b0, 1'b1);
    check("last_sample", 32'(last_byte), CSUM != 0 ? 32'h00 : 32'h8F);
    run_frame(8'h05, 1'b0, 1'b1);

    // Backpressure
    ready_rand = 1'b1;
    run_frame(8'h10, 1'b0, 1'b0);
    load_mem(1'b1);
    run_frame(8'($urandom), 1'b0, 1'b0);
    run_frame(8'($urandom), 1'b1, 1'b0);
    ready_rand = 1'b0;

    // Reset mid-frame after 40 accepted bytes
    load_mem(1'b0);
    acc0 = accepted;
    cyc  = 0;
    expect_frame(8'h10);
    trig_offset = 8'h10;
    activate    = 1'b1;
    while (accepted - acc0 < 40 && cyc < 2000) begin
      tick(1);
      cyc++;
    end
    check("reached_40_bytes", 32'(accepted - acc0), 32'd40);
    reset    = 1'b1;
    activate = 1'b0;
    tick(1);
    check_reset_outputs("midrst");
    reset = 1'b0;
    exp_q.delete();
    addr_q.delete();
    tick(3);
    check("no_bytes_after_reset", 32'(accepted - acc0), 32'd40);
    run_frame(8'h10, 1'b0, 1'b1);

    // Activate dropped after header, ready=1
    run_frame(8'h10, 1'b1, 1'b1);

    // Checksum pattern
    load_mem(1'b0);
    mem[8'h90] = 8'hFF;
    run_frame(8'h10, 1'b0, 1'b1);
    check("final_byte", 32'(last_byte), CSUM != 0 ? 32'h6F : 32'h8F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
